// File: rtl/stopwatch_pkg.sv
// Shared types and field limits for the stopwatch / countdown timer family.
package stopwatch_pkg;

  localparam int MIN_W   = 7;
  localparam int SEC_W   = 7;
  localparam int CENTI_W = 8;

  localparam logic [CENTI_W-1:0] CENTI_MAX = 8'd99;
  localparam logic [SEC_W-1:0]   SEC_MAX   = 7'd59;
  localparam logic [MIN_W-1:0]   MIN_MAX   = 7'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
    return (v > MIN_MAX) ? MIN_MAX : v;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] v);
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

  function automatic logic [CENTI_W-1:0] clamp_centi(input logic [CENTI_W-1:0] v);
    return (v > CENTI_MAX) ? CENTI_MAX : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Centisecond prescaler: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = $clog2(TICK_DIV + 1);
  localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] cnt_r;

  assign tick = en && (cnt_r == LAST);

  // Prescaler count; clr dominates, holds its value when not enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + PS_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: min:sec:centi preset decremented once per centisecond tick until expiry.
module countdown_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [MIN_W-1:0]   min_in,
  input  logic [SEC_W-1:0]   sec_in,
  input  logic [CENTI_W-1:0] centi_in,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [MIN_W-1:0]   min,
  output logic [SEC_W-1:0]   sec,
  output logic [CENTI_W-1:0] centi,
  output logic               running,
  output logic               zero,
  output logic               expired
);

  timer_state_t       state_r;
  logic [MIN_W-1:0]   min_r;
  logic [SEC_W-1:0]   sec_r;
  logic [CENTI_W-1:0] centi_r;
  logic               running_r;
  logic               expired_r;

  logic [MIN_W-1:0]   dec_min_s;
  logic [SEC_W-1:0]   dec_sec_s;
  logic [CENTI_W-1:0] dec_centi_s;
  logic               dec_zero_s;
  logic               run_en_s;
  logic               ps_clr_s;
  logic               tick_s;

  assign min     = min_r;
  assign sec     = sec_r;
  assign centi   = centi_r;
  assign running = running_r;
  assign expired = expired_r;
  assign zero    = (min_r == 7'd0) && (sec_r == 7'd0) && (centi_r == 8'd0);

  // Borrow chain: value one centisecond lower, saturating at 0:00:00
  always_comb begin
    dec_min_s   = min_r;
    dec_sec_s   = sec_r;
    dec_centi_s = centi_r;
    if (centi_r != 8'd0) begin
      dec_centi_s = centi_r - 8'd1;
    end else if (sec_r != 7'd0) begin
      dec_centi_s = CENTI_MAX;
      dec_sec_s   = sec_r - 7'd1;
    end else if (min_r != 7'd0) begin
      dec_centi_s = CENTI_MAX;
      dec_sec_s   = SEC_MAX;
      dec_min_s   = min_r - 7'd1;
    end else begin
      dec_centi_s = 8'd0;
    end
  end

  assign dec_zero_s = (dec_min_s == 7'd0) && (dec_sec_s == 7'd0) && (dec_centi_s == 8'd0);

  // Any higher-priority strobe freezes the prescaler, so a stop in the tick cycle cancels it
  assign run_en_s = (state_r == RUNNING) && !clear && !load && !stop;
  assign ps_clr_s = clear || load || (tick_s && dec_zero_s);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (run_en_s),
    .clr  (ps_clr_s),
    .tick (tick_s)
  );

  // Control FSM and time value registers; strobe priority clear > load > stop > start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      min_r     <= 7'd0;
      sec_r     <= 7'd0;
      centi_r   <= 8'd0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else if (clear) begin
      state_r   <= IDLE;
      min_r     <= 7'd0;
      sec_r     <= 7'd0;
      centi_r   <= 8'd0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else if (load) begin
      state_r   <= IDLE;
      min_r     <= clamp_min(min_in);
      sec_r     <= clamp_sec(sec_in);
      centi_r   <= clamp_centi(centi_in);
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      expired_r <= 1'b0;
      case (state_r)
        IDLE, PAUSED: begin
          if (start && !stop && !zero) begin
            state_r   <= RUNNING;
            running_r <= 1'b1;
          end else begin
            running_r <= 1'b0;
          end
        end
        RUNNING: begin
          if (stop) begin
            state_r   <= PAUSED;
            running_r <= 1'b0;
          end else if (tick_s) begin
            min_r   <= dec_min_s;
            sec_r   <= dec_sec_s;
            centi_r <= dec_centi_s;
            if (dec_zero_s) begin
              state_r   <= EXPIRED;
              running_r <= 1'b0;
              expired_r <= 1'b1;
            end else begin
              running_r <= 1'b1;
            end
          end else begin
            running_r <= 1'b1;
          end
        end
        EXPIRED: begin
          running_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV=4.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [6:0] min_in = 7'd0;
  logic [6:0] sec_in = 7'd0;
  logic [7:0] centi_in = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] min;
  logic [6:0] sec;
  logic [7:0] centi;
  logic       running;
  logic       zero;
  logic       expired;

  int checks = 0;
  int failures = 0;
  int exp_pulses = 0;

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .min_in  (min_in),
    .sec_in  (sec_in),
    .centi_in(centi_in),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .min     (min),
    .sec     (sec),
    .centi   (centi),
    .running (running),
    .zero    (zero),
    .expired (expired)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (expired === 1'b1) exp_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_val(input string tag, input int m, input int s, input int c);
    chk({tag, "_min"}, 32'(min), 32'(m));
    chk({tag, "_sec"}, 32'(sec), 32'(s));
    chk({tag, "_centi"}, 32'(centi), 32'(c));
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int m, input int s, input int c);
    min_in = 7'(m);
    sec_in = 7'(s);
    centi_in = 8'(c);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    // reset in progress
    #1 reset = 1'b0;
    #2;
    chk_val("rst", 0, 0, 0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_expired", 32'(expired), 32'd0);
    #20 reset = 1'b1;
    cyc();

    // start with value zero is ignored
    do_start();
    chk("start0_running", 32'(running), 32'd0);
    cyc(5);
    chk("start0_pulses", 32'(exp_pulses), 32'd0);

    // full countdown 0:01:05 -> expiry after 105 ticks
    do_load(0, 1, 5);
    chk_val("load105", 0, 1, 5);
    do_start();
    chk("run105_running", 32'(running), 32'd1);
    cyc(419);
    chk_val("pre_exp", 0, 0, 1);
    chk("pre_exp_expired", 32'(expired), 32'd0);
    cyc();
    chk("exp_expired", 32'(expired), 32'd1);
    chk_val("exp", 0, 0, 0);
    chk("exp_running", 32'(running), 32'd0);
    chk("exp_zero", 32'(zero), 32'd1);
    cyc();
    chk("exp_pulse_end", 32'(expired), 32'd0);
    do_start();
    chk("exp_start_running", 32'(running), 32'd0);
    chk("exp_pulses", 32'(exp_pulses), 32'd1);

    // borrow through minutes and seconds
    do_load(1, 0, 0);
    do_start();
    cyc(3);
    chk_val("borrow_m_pre", 1, 0, 0);
    cyc();
    chk_val("borrow_m", 0, 59, 99);
    do_load(0, 1, 0);
    chk("load_stops_running", 32'(running), 32'd0);
    do_start();
    cyc(4);
    chk_val("borrow_s", 0, 0, 99);

    // clamping
    do_load(80, 75, 200);
    chk_val("clamp", 59, 59, 99);
    chk("clamp_running", 32'(running), 32'd0);
    do_load(60, 60, 100);
    chk_val("clamp_edge", 59, 59, 99);

    // start and stop together in IDLE: stop wins and is ignored
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_idle_running", 32'(running), 32'd0);

    // pause / resume with held prescaler
    do_load(0, 0, 10);
    do_start();
    cyc(6);
    chk_val("pause_pre", 0, 0, 9);
    do_stop();
    chk("pause_running", 32'(running), 32'd0);
    chk_val("pause", 0, 0, 9);
    cyc(20);
    chk_val("pause_hold", 0, 0, 9);
    chk("pause_hold_running", 32'(running), 32'd0);
    do_start();
    chk("resume_running", 32'(running), 32'd1);
    cyc();
    chk_val("resume_1", 0, 0, 9);
    cyc();
    chk_val("resume_2", 0, 0, 8);

    // stop in the tick cycle cancels the decrement
    cyc(3);
    chk_val("stoptick_pre", 0, 0, 8);
    do_stop();
    chk_val("stoptick", 0, 0, 8);
    chk("stoptick_running", 32'(running), 32'd0);
    do_start();
    cyc();
    chk_val("stoptick_resume", 0, 0, 7);

    // asynchronous reset while running
    do_load(0, 0, 50);
    do_start();
    cyc(2);
    chk_val("midrun_pre", 0, 0, 50);
    #2 reset = 1'b0;
    #1;
    chk_val("midrun_rst", 0, 0, 0);
    chk("midrun_rst_running", 32'(running), 32'd0);
    chk("midrun_rst_zero", 32'(zero), 32'd1);
    #3 reset = 1'b1;
    cyc();

    // clear beats load
    do_load(0, 0, 30);
    chk_val("preclear", 0, 0, 30);
    min_in = 7'd0;
    sec_in = 7'd1;
    centi_in = 8'd5;
    clear = 1'b1;
    load = 1'b1;
    cyc();
    clear = 1'b0;
    load = 1'b0;
    chk_val("clear_load", 0, 0, 0);
    chk("clear_load_zero", 32'(zero), 32'd1);
    chk("final_pulses", 32'(exp_pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Count-down companion to the stopwatch. It is loaded with a min:sec:centi preset and decrements once per centisecond tick. It reaches 00:00:00, stops and signals expiry. The field encodings match the stopwatch outputs: binary min 0-59, sec 0-59, centi 0-99.

Parameters:
TICK_DIV, 4, clk cycles per centisecond tick (>=1); 1 means decrement every enabled cycle
PS_W, $clog2(TICK_DIV+1), prescaler counter width (derived, do not override)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
load  in  1  1-cycle strobe: capture min_in/sec_in/centi_in, enter IDLE
min_in  in  7  preset minutes
sec_in  in  7  preset seconds
centi_in  in  8  preset centiseconds
start  in  1  1-cycle strobe: begin/resume counting
stop  in  1  1-cycle strobe: pause counting
clear  in  1  1-cycle strobe: value to zero, enter IDLE
min  out  7  current minutes
sec  out  7  current seconds
centi  out  8  current centiseconds
running  out  1  high in RUNNING
zero  out  1  combinational: min==0 && sec==0 && centi==0
expired  out  1  1-cycle pulse on reaching zero while running

Behaviour:
- Reset (reset==0, async): min/sec/centi=0, prescaler=0, state=IDLE, running=0, expired=0; zero=1.
- States: IDLE, RUNNING, PAUSED, EXPIRED. All registers update on posedge clk.
- Strobe priority, highest first: clear > load > stop > start. Only the highest-priority active strobe acts.
- clear (any state): value=0, prescaler=0, state=IDLE.
- load (any state): value=clamped inputs, prescaler=0, state=IDLE.
- Clamp rules: min_in>59 -> 59; sec_in>59 -> 59; centi_in>99 -> 99.
- start, from IDLE or PAUSED, value nonzero: state=RUNNING next cycle.
- start with value zero: ignored; no expired pulse.
- start in RUNNING or EXPIRED: ignored.
- stop in RUNNING: state=PAUSED; prescaler holds its value (not cleared).
- stop in any other state: ignored.
- Prescaler runs only in RUNNING. It counts 0..TICK_DIV-1 and raises an internal tick when it equals TICK_DIV-1, then wraps to 0.
- First tick occurs TICK_DIV cycles after running rises when starting from prescaler=0.
- Decrement on tick:
  - centi>0: centi-1.
  - centi==0, sec>0: centi=99, sec-1.
  - centi==0, sec==0, min>0: centi=99, sec=59, min-1.
- Expiry: if the post-decrement value is 0:00:00, then in the same edge state=EXPIRED, prescaler=0, and expired=1 for exactly one cycle.
- EXPIRED: value stays 0, running=0. Exit only via load, clear or reset.
- A tick and a stop in the same cycle: stop wins; no decrement.
- Outputs are never outside their ranges. No arithmetic wrap below zero can occur.

Decomposition:
- Package stopwatch_pkg:
  - timer_state_t enum {IDLE, RUNNING, PAUSED, EXPIRED}
  - constants CENTI_MAX=8'd99, SEC_MAX=7'd59, MIN_MAX=7'd59
  - MIN_W=7, SEC_W=7, CENTI_W=8
  - shared with the stopwatch.
- One sub-module, tick_gen (parameter TICK_DIV; ports clk, reset, en, clr, tick). The FSM and the borrow chain stay in countdown_timer.

Test Plan (TICK_DIV=4):
- Reset in progress -> min/sec/centi=0, zero=1, running=0. Release reset, pulse start -> state stays IDLE, expired never asserts.
- Load 0:01:05, start -> running=1 next cycle; after 105 ticks (420 cycles) expired pulses once, value 0:00:00, running=0, zero=1.
- Borrow: load 1:00:00, start, 4 cycles -> 0:59:99. Load 0:01:00, start, one tick -> 0:00:99.
- Clamp: load min_in=80, sec_in=75, centi_in=200 -> outputs 59:59:99.
- Pause/resume:
  - Load 0:00:10, start, stop after 6 cycles -> value 0:00:09, prescaler 2 held.
  - Wait 20 cycles -> unchanged.
  - start -> next decrement 2 cycles after running rises.
  - Simultaneous stop+tick -> no decrement.
- Reset mid-run: assert reset asynchronously between edges while RUNNING at 0:00:50 -> outputs 0 immediately, before the next clk edge. clear+load together -> value 0 (clear wins).
